// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU datapath blocks.
// Holds the sequencer state encoding, the default width and the counter sizing helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ALU_WIDTH = 8;

  // Bit counter must index 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_adder.sv
// Single-bit full adder used by the bit-serial ALU engine.
module bit_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic result,
  output logic carry_out
);

  assign result    = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial add/subtract engine: latches two operands and streams them LSB-first
// through one bit_adder, one bit per clock, assembling the result in a shift register.
module serial_adder_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_IN   = CW'(WIDTH - 2);

  // Handshake: start is accepted on a rising edge only in IDLE or DONE (busy=0);
  // done is a one-cycle pulse marking result/carry_out/overflow valid, which then
  // hold until the next accepted operation completes. start during busy is dropped.

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry_reg;
  logic             c_msb_in;
  logic             bit_sum;
  logic             bit_co;
  logic             load;
  logic             last_bit;

  bit_adder u_bit_adder (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (carry_reg),
    .result    (bit_sum),
    .carry_out (bit_co)
  );

  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);
  assign last_bit = (state == SHIFT) && (cnt == LAST_BIT);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry_reg <= 1'b0;
      c_msb_in  <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
        a_sh      <= a;
        b_sh      <= sub ? ~b : b;
        carry_reg <= sub;
        cnt       <= '0;
      end else if (state == SHIFT) begin
        a_sh      <= a_sh >> 1;
        b_sh      <= b_sh >> 1;
        res_sh    <= {bit_sum, res_sh[WIDTH-1:1]};
        carry_reg <= bit_co;
        cnt       <= cnt + 1'b1;
        if (cnt == MSB_IN) c_msb_in <= bit_co;
        if (last_bit) begin
          result    <= {bit_sum, res_sh[WIDTH-1:1]};
          carry_out <= bit_co;
          overflow  <= c_msb_in ^ bit_co;
        end
      end
    end
  end

endmodule
